seq_detect_ctrl: RTL and testbench
==================================

SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 Parameter N, default 4, width in bits of one digit.
REQ-002 Parameter DIGITS, default 8, number of digits per request word.
REQ-003 Parameter CNT_W, default 8, width of match counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 asyn_rst  input  1  reset, asynchronous and active-high.
REQ-006 req_valid  input  2  per-requester request valid; bit i belongs to requester i.
REQ-007 req_word0  input  DIGITS*N  digit word of requester 0.
REQ-008 req_word1  input  DIGITS*N  digit word of requester 1.
REQ-009 req_ready  output  2  one-hot accept pulse to the granted requester.
REQ-010 det_rst  output  1  active-high clear to the sequence detector.
REQ-011 det_start  output  1  start pulse to the detector.
REQ-012 det_digit  output  N  digit driven into the detector.
REQ-013 det_detected  input  1  Mealy detect output from the detector, combinational in the same cycle.
REQ-014 resp_valid  output  1  result available.
REQ-015 resp_ready  input  1  result consumed.
REQ-016 resp_match  output  1  1 = word contained the target sequence at its final digit.
REQ-017 resp_id  output  1  requester index of the result.
REQ-018 match_count  output  CNT_W  count of matched results.
REQ-019 busy  output  1  high in every state except IDLE.

Function
REQ-020 FSM states: IDLE, CLR, START, FEED, DONE.
REQ-021 IDLE: if any req_valid is set, grant one requester, drive its req_ready bit high that cycle, latch its word and id, and go to CLR.
REQ-022 Arbitration: round-robin; if both are valid, grant the requester not granted last; if only one is valid, grant it.
REQ-023 After reset the last-grant pointer equals 1, so requester 0 wins the first tie.
REQ-024 CLR: det_rst=1 for exactly one cycle, then go to START.
REQ-025 START: det_start=1 for exactly one cycle, then go to FEED with digit index k=0.
REQ-026 FEED: det_digit = word[(DIGITS-1-k)*N +: N] (most significant digit first); k increments each cycle.
REQ-027 FEED lasts exactly DIGITS cycles.
REQ-028 In the FEED cycle with k=DIGITS-1, capture det_detected into resp_match, then go to DONE.
REQ-029 det_detected in all other cycles is ignored.
REQ-030 DONE: resp_valid=1; resp_match and resp_id are held stable until resp_ready=1.
REQ-031 On DONE with resp_ready=1, go to IDLE; that same cycle, match_count increments if resp_match=1.
REQ-032 match_count saturates at 2^CNT_W-1.
REQ-033 Latency: accept in cycle T, CLR in T+1, START in T+2, FEED in T+3..T+2+DIGITS, resp_valid first high in T+3+DIGITS (T+11 at the default).
REQ-034 req_valid is not sampled outside IDLE; at most one req_ready bit is high per cycle.
REQ-035 det_start, det_rst and det_digit are 0 in every state other than the one that drives them.
REQ-036 A new grant may occur in the IDLE cycle directly after DONE.

Reset
REQ-037 When asyn_rst=1, immediately set: state IDLE, k=0, last-grant=1, match_count=0, resp_match=0, resp_id=0, and all outputs 0.
REQ-038 Assertion mid-transaction aborts it; no response is issued for the aborted word, and match_count is not changed.

Verification
REQ-039 req_valid=01, req_word0=32'h82444300, resp_ready=1 -> det_rst pulse at T+1, det_start at T+2, digits 8,2,4,4,4,3,0,0 at T+3..T+10, resp_valid=1 with resp_match=1, resp_id=0 at T+11, match_count=1.
REQ-040 req_valid=10, req_word1=32'h82444301 -> resp_match=0, resp_id=1, match_count unchanged.
REQ-041 req_valid=11 held across three transactions -> grants 0,1,0; req_ready one-hot in each accept cycle.
REQ-042 resp_ready held 0 for 5 cycles in DONE -> resp_valid, resp_match and resp_id stable, no new req_ready, busy=1.
REQ-043 asyn_rst pulsed during FEED at k=4 -> all outputs 0 immediately, no response, match_count unchanged, next request starts from CLR normally.
REQ-044 With CNT_W=2, four matching words -> match_count reads 1,2,3,3.

Source files
------------

// File: rtl/seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_ctrl
// Brief    : Two-requester round-robin front end that streams a digit word,
//            most significant digit first, into an external sequence detector.
// Revision : 1.0 - initial release
// ============================================================================
module seq_detect_ctrl #(
  parameter int N      = 4,
  parameter int DIGITS = 8,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  asyn_rst,
  input  logic [1:0]            req_valid,
  input  logic [DIGITS*N-1:0]   req_word0,
  input  logic [DIGITS*N-1:0]   req_word1,
  output logic [1:0]            req_ready,
  output logic                  det_rst,
  output logic                  det_start,
  output logic [N-1:0]          det_digit,
  input  logic                  det_detected,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_match,
  output logic                  resp_id,
  output logic [CNT_W-1:0]      match_count,
  output logic                  busy
);

  localparam int             K_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [K_W-1:0] c_K_LAST = K_W'(DIGITS - 1);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_CLR   = 3'd1;
  localparam logic [2:0] c_START = 3'd2;
  localparam logic [2:0] c_FEED  = 3'd3;
  localparam logic [2:0] c_DONE  = 3'd4;

  logic [2:0]          r_state;
  logic [2:0]          w_next_state;
  logic [DIGITS*N-1:0] r_word;
  logic [DIGITS*N-1:0] w_shifted;
  logic                r_id;
  logic                r_last;
  logic                r_resp_match;
  logic [K_W-1:0]      r_k;
  logic [CNT_W-1:0]    r_match_count;
  logic                w_grant;
  logic                w_grant_id;

  // Round-robin only matters on a tie; a lone requester always wins.
  always_comb begin
    w_grant_id = 1'b0;
    if (req_valid == 2'b11) w_grant_id = ~r_last;
    else if (req_valid[1])  w_grant_id = 1'b1;
  end

  assign w_grant = (r_state == c_IDLE) && (req_valid != 2'b00);

  always_ff @(posedge clk or posedge asyn_rst) begin
    if (asyn_rst) r_state <= c_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:  if (w_grant) w_next_state = c_CLR;
      c_CLR:   w_next_state = c_START;
      c_START: w_next_state = c_FEED;
      c_FEED:  if (r_k == c_K_LAST) w_next_state = c_DONE;
      c_DONE:  if (resp_ready) w_next_state = c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge asyn_rst) begin
    if (asyn_rst) begin
      r_word        <= '0;
      r_id          <= 1'b0;
      r_last        <= 1'b1;
      r_k           <= '0;
      r_resp_match  <= 1'b0;
      r_match_count <= '0;
    end else begin
      case (r_state)
        c_IDLE: if (w_grant) begin
          r_word <= w_grant_id ? req_word1 : req_word0;
          r_id   <= w_grant_id;
          r_last <= w_grant_id;
        end
        c_START: r_k <= '0;
        c_FEED: begin
          r_k <= r_k + K_W'(1);
          if (r_k == c_K_LAST) r_resp_match <= det_detected;
        end
        c_DONE: if (resp_ready && r_resp_match && (r_match_count != {CNT_W{1'b1}}))
          r_match_count <= r_match_count + CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Shifting left by k digits puts digit k in the top slot.
  assign w_shifted = r_word << (N * int'(r_k));

  always_comb begin
    req_ready  = 2'b00;
    det_rst    = 1'b0;
    det_start  = 1'b0;
    det_digit  = '0;
    resp_valid = 1'b0;
    busy       = (r_state != c_IDLE);
    case (r_state)
      c_IDLE:  if (w_grant && !asyn_rst) req_ready = w_grant_id ? 2'b10 : 2'b01;
      c_CLR:   det_rst    = 1'b1;
      c_START: det_start  = 1'b1;
      c_FEED:  det_digit  = w_shifted[DIGITS*N-1 -: N];
      c_DONE:  resp_valid = 1'b1;
      default: ;
    endcase
  end

  assign resp_match  = r_resp_match;
  assign resp_id     = r_id;
  assign match_count = r_match_count;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_detect_ctrl
// Brief    : Scoreboard bench for seq_detect_ctrl with a behavioural detector
//            that flags the digit run 4,3,0,0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detect_ctrl;

  localparam int N      = 4;
  localparam int DIGITS = 8;
  localparam int CNT_W  = 8;
  localparam int W      = DIGITS * N;

  logic             clk = 1'b0;
  logic             asyn_rst;
  logic [1:0]       req_valid;
  logic [W-1:0]     req_word0;
  logic [W-1:0]     req_word1;
  logic [1:0]       req_ready;
  logic             det_rst;
  logic             det_start;
  logic [N-1:0]     det_digit;
  logic             det_detected;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_match;
  logic             resp_id;
  logic [CNT_W-1:0] match_count;
  logic             busy;

  always #5 clk = ~clk;

  seq_detect_ctrl #(.N(N), .DIGITS(DIGITS), .CNT_W(CNT_W)) u_dut (
    .clk          (clk),
    .asyn_rst     (asyn_rst),
    .req_valid    (req_valid),
    .req_word0    (req_word0),
    .req_word1    (req_word1),
    .req_ready    (req_ready),
    .det_rst      (det_rst),
    .det_start    (det_start),
    .det_digit    (det_digit),
    .det_detected (det_detected),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_match   (resp_match),
    .resp_id      (resp_id),
    .match_count  (match_count),
    .busy         (busy)
  );

  // Mealy detector: current digit completes 4,3,0,0 after the last clear/start.
  logic [3*N-1:0] hist;
  always @(posedge clk or posedge asyn_rst) begin
    if (asyn_rst)                   hist <= '0;
    else if (det_rst || det_start)  hist <= '0;
    else                            hist <= {hist[2*N-1:0], det_digit};
  end
  assign det_detected = ({hist, det_digit} == 16'h4300);

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic         id;
    logic [W-1:0] word;
    logic         match;
    int           t;
  } exp_t;

  exp_t             sb[$];
  int               cyc    = 0;
  logic             m_busy = 1'b0;
  logic             m_last = 1'b1;
  logic [CNT_W-1:0] m_cnt  = '0;

  // Monitor / reference model, evaluated mid-cycle.
  always @(negedge clk) begin
    exp_t         e;
    int           ph;
    logic [1:0]   e_ready;
    logic         e_rst, e_start, e_valid;
    logic [N-1:0] e_digit;
    logic [W-1:0] tmp;
    cyc++;
    if (asyn_rst) begin
      check("reset_outputs", {req_ready, det_rst, det_start, det_digit, resp_valid,
                              resp_match, resp_id, match_count, busy}, 64'd0);
      sb.delete();
      m_busy = 1'b0;
      m_last = 1'b1;
      m_cnt  = '0;
    end else begin
      check("match_count", match_count, m_cnt);
      check("busy", busy, m_busy);
      e_ready = 2'b00; e_rst = 1'b0; e_start = 1'b0; e_valid = 1'b0; e_digit = '0;
      if (!m_busy && req_valid != 2'b00) begin
        e.id    = (req_valid == 2'b11) ? ~m_last : req_valid[1];
        e.word  = e.id ? req_word1 : req_word0;
        e.match = (e.word[4*N-1:0] == 16'h4300);
        e.t     = cyc;
        sb.push_back(e);
        m_last  = e.id;
        m_busy  = 1'b1;
        e_ready = e.id ? 2'b10 : 2'b01;
      end else if (m_busy && sb.size() > 0) begin
        ph      = cyc - sb[0].t;
        e_rst   = (ph == 1);
        e_start = (ph == 2);
        if (ph >= 3 && ph <= 2 + DIGITS) begin
          tmp     = sb[0].word >> ((DIGITS - 1 - (ph - 3)) * N);
          e_digit = tmp[N-1:0];
        end
        e_valid = (ph >= 3 + DIGITS);
        if (e_valid) begin
          check("resp_id", resp_id, sb[0].id);
          check("resp_match", resp_match, sb[0].match);
          if (resp_ready) begin
            if (sb[0].match && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
            void'(sb.pop_front());
            m_busy = 1'b0;
          end
        end
      end
      check("req_ready", req_ready, e_ready);
      check("det_rst", det_rst, e_rst);
      check("det_start", det_start, e_start);
      check("det_digit", det_digit, e_digit);
      check("resp_valid", resp_valid, e_valid);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] mk_word();
    logic [W-1:0] w;
    w = W'($urandom);
    if ($urandom_range(0, 9) < 8) w[15:0] = 16'h4300;
    return w;
  endfunction

  initial begin
    asyn_rst   = 1'b1;
    req_valid  = 2'b00;
    req_word0  = '0;
    req_word1  = '0;
    resp_ready = 1'b0;
    step(2);
    asyn_rst = 1'b0;
    step(1);

    // Matching word from requester 0.
    req_word0 = 32'h82444300; req_valid = 2'b01; resp_ready = 1'b1;
    step(1); req_valid = 2'b00; step(14);

    // Last digit differs: no match from requester 1.
    req_word1 = 32'h82444301; req_valid = 2'b10;
    step(1); req_valid = 2'b00; step(14);

    // Both requesting continuously: alternating grants.
    req_word0 = 32'h11114300; req_word1 = 32'h12345678; req_valid = 2'b11;
    step(36); req_valid = 2'b00; step(14);

    // Back-pressure in DONE.
    resp_ready = 1'b0; req_word0 = 32'h99994300; req_valid = 2'b01;
    step(1); req_word0 = 32'h0; req_valid = 2'b11; step(16);
    req_valid = 2'b00; resp_ready = 1'b1; step(14);

    // Reset asserted during FEED with k=4.
    req_word1 = 32'h55554300; req_valid = 2'b10;
    step(1); req_valid = 2'b00; step(6);
    asyn_rst = 1'b1;
    #1;
    check("async_reset_immediate", {req_ready, det_rst, det_start, det_digit, resp_valid,
                                    resp_match, resp_id, match_count, busy}, 64'd0);
    @(posedge clk); #1;
    asyn_rst = 1'b0;
    step(1);
    req_word0 = 32'h00004300; req_valid = 2'b01;
    step(1); req_valid = 2'b00; step(14);

    // Randomised traffic long enough to saturate the counter.
    for (int i = 0; i < 7000; i++) begin
      req_valid  = ($urandom_range(0, 9) < 8) ? 2'($urandom_range(1, 3)) : 2'b00;
      req_word0  = mk_word();
      req_word1  = mk_word();
      resp_ready = ($urandom_range(0, 9) < 7);
      step(1);
    end
    req_valid = 2'b00; resp_ready = 1'b1;
    step(20);
    check("match_count_saturated", match_count, {CNT_W{1'b1}});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
